// File: rtl/apb_dec_split_pkg.sv
// Shared types and helpers for the APB decoding splitter.
package apb_dec_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // Never returns less than 1 so that single-entry parameters still yield a legal vector width.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/apb_range_dec.sv
// Multi-range, per-master visibility filtered, lowest-index-wins APB address decoder.
module apb_range_dec
  import apb_dec_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MASTER_NUM = 2,
  parameter int SLAVE_NUM  = 5,
  parameter int RANGE_NUM  = 2,
  parameter logic [SLAVE_NUM*RANGE_NUM*ADDR_WIDTH-1:0] SLAVE_START_ADDRS = '0,
  parameter logic [SLAVE_NUM*RANGE_NUM*ADDR_WIDTH-1:0] SLAVE_END_ADDRS   = '0,
  parameter logic [SLAVE_NUM*RANGE_NUM-1:0]            SLAVE_RANGE_EN    = '0,
  parameter logic [MASTER_NUM*SLAVE_NUM-1:0]           SLAVE_VISIBLE     = '1
) (
  input  logic [clog2_w(MASTER_NUM)-1:0] master_id,
  input  logic [ADDR_WIDTH-1:0]          addr,
  output logic [SLAVE_NUM-1:0]           hit_vec,
  output logic                           hit
);

  logic [SLAVE_NUM-1:0] in_range;
  logic [SLAVE_NUM-1:0] visible;

  always_comb begin
    in_range = '0;
    for (int s = 0; s < SLAVE_NUM; s++) begin
      for (int r = 0; r < RANGE_NUM; r++) begin
        if (SLAVE_RANGE_EN[s*RANGE_NUM+r] &&
            addr >= SLAVE_START_ADDRS[(s*RANGE_NUM+r)*ADDR_WIDTH +: ADDR_WIDTH] &&
            addr <= SLAVE_END_ADDRS[(s*RANGE_NUM+r)*ADDR_WIDTH +: ADDR_WIDTH])
          in_range[s] = 1'b1;
      end
    end
  end

  // IDs at or above MASTER_NUM match no row and therefore see nothing.
  always_comb begin
    visible = '0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      for (int s = 0; s < SLAVE_NUM; s++) begin
        if (int'(master_id) == m)
          visible[s] = SLAVE_VISIBLE[m*SLAVE_NUM+s];
      end
    end
  end

  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    for (int s = 0; s < SLAVE_NUM; s++) begin
      if (in_range[s] && visible[s] && !hit) begin
        hit_vec[s] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_dec_split.sv
// Registered APB 1-to-N splitter with multi-range decode and internal error slave.
// Optional access-phase timeout is compiled in with APB_DEC_SPLIT_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for an upstream setup phase
// SETUP  | downstream PSEL asserted, PENABLE low
// ACCESS | downstream PENABLE high, waiting for selected PREADY
// ERR    | one-cycle error completion for unmapped/invisible address
module apb_dec_split
  import apb_dec_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASTER_NUM = 2,
  parameter int SLAVE_NUM  = 5,
  parameter int RANGE_NUM  = 2,
  parameter logic [SLAVE_NUM*RANGE_NUM*ADDR_WIDTH-1:0] SLAVE_START_ADDRS = {
    32'h0000_0000, 32'h0008_0000, 32'h0000_0000, 32'h0007_0000, 32'h0000_0000,
    32'h0006_0000, 32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 32'h0004_0000},
  parameter logic [SLAVE_NUM*RANGE_NUM*ADDR_WIDTH-1:0] SLAVE_END_ADDRS = {
    32'h0000_0000, 32'h0008_FFFF, 32'h0000_0000, 32'h0007_FFFF, 32'h0000_0000,
    32'h0006_FFFF, 32'h0000_0000, 32'h0005_FFFF, 32'h0000_0000, 32'h0004_FFFF},
  parameter logic [SLAVE_NUM*RANGE_NUM-1:0]  SLAVE_RANGE_EN = 10'h155,
  parameter logic [MASTER_NUM*SLAVE_NUM-1:0] SLAVE_VISIBLE  = '1,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [clog2_w(MASTER_NUM)-1:0]  s_master_id,
  input  logic                            s_psel,
  input  logic                            s_penable,
  input  logic                            s_pwrite,
  input  logic [ADDR_WIDTH-1:0]           s_paddr,
  input  logic [DATA_WIDTH-1:0]           s_pwdata,
  output logic [DATA_WIDTH-1:0]           s_prdata,
  output logic                            s_pready,
  output logic                            s_pslverr,
  output logic [SLAVE_NUM-1:0]            m_psel,
  output logic                            m_penable,
  output logic                            m_pwrite,
  output logic [ADDR_WIDTH-1:0]           m_paddr,
  output logic [DATA_WIDTH-1:0]           m_pwdata,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] m_prdata,
  input  logic [SLAVE_NUM-1:0]            m_pready,
  input  logic [SLAVE_NUM-1:0]            m_pslverr
);

  localparam logic [DATA_WIDTH-1:0] DATA_RST = {DATA_WIDTH{DATA_RST_BIT}};

  state_t                state;
  logic [SLAVE_NUM-1:0]  dec_vec;
  logic                  dec_hit;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;

  apb_range_dec #(
    .ADDR_WIDTH        (ADDR_WIDTH),
    .MASTER_NUM        (MASTER_NUM),
    .SLAVE_NUM         (SLAVE_NUM),
    .RANGE_NUM         (RANGE_NUM),
    .SLAVE_START_ADDRS (SLAVE_START_ADDRS),
    .SLAVE_END_ADDRS   (SLAVE_END_ADDRS),
    .SLAVE_RANGE_EN    (SLAVE_RANGE_EN),
    .SLAVE_VISIBLE     (SLAVE_VISIBLE)
  ) u_dec (
    .master_id (s_master_id),
    .addr      (s_paddr),
    .hit_vec   (dec_vec),
    .hit       (dec_hit)
  );

  // m_psel is one-hot, so masking with it selects the addressed slave's response.
  assign sel_ready = |(m_pready & m_psel);
  assign sel_err   = |(m_pslverr & m_psel);

  always_comb begin
    sel_rdata = '0;
    for (int s = 0; s < SLAVE_NUM; s++) begin
      if (m_psel[s])
        sel_rdata = sel_rdata | m_prdata[s*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef APB_DEC_SPLIT_TIMEOUT_EN
  localparam int TO_W = clog2_w(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt;

  // Held at zero outside ACCESS so every access phase starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (state != ST_ACCESS)
      to_cnt <= '0;
    else if (!sel_ready)
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_ACCESS) && !sel_ready &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // Without the timeout build the limit never fires; the comparison is constant false.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = DATA_RST;
    unique case (state)
      ST_ACCESS: begin
        if (sel_ready) begin
          s_pready  = 1'b1;
          s_pslverr = sel_err;
          s_prdata  = sel_rdata;
        end else if (timeout_hit) begin
          s_pready  = 1'b1;
          s_pslverr = 1'b1;
        end
      end
      ST_ERR: begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      m_psel    <= '0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= DATA_RST;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (s_psel && !s_penable) begin
            m_paddr  <= s_paddr;
            m_pwdata <= s_pwdata;
            m_pwrite <= s_pwrite;
            if (dec_hit) begin
              m_psel <= dec_vec;
              state  <= ST_SETUP;
            end else begin
              state  <= ST_ERR;
            end
          end
        end
        ST_SETUP: begin
          m_penable <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready || timeout_hit) begin
            m_psel    <= '0;
            m_penable <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_ERR: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_dec_split.sv
// Directed self-checking bench for apb_dec_split (timeout case runs when APB_DEC_SPLIT_TIMEOUT_EN is defined).
module tb_apb_dec_split;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MN = 2;
  localparam int SN = 5;
  localparam int RN = 2;

  // Slave 3 gets a second range; master 1 cannot see slave 2.
  localparam logic [SN*RN*AW-1:0] STARTS = {
    32'h0000_0000, 32'h0008_0000, 32'h0010_0000, 32'h0007_0000, 32'h0000_0000,
    32'h0006_0000, 32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 32'h0004_0000};
  localparam logic [SN*RN*AW-1:0] ENDS = {
    32'h0000_0000, 32'h0008_FFFF, 32'h0010_0FFF, 32'h0007_FFFF, 32'h0000_0000,
    32'h0006_FFFF, 32'h0000_0000, 32'h0005_FFFF, 32'h0000_0000, 32'h0004_FFFF};
  localparam logic [SN*RN-1:0] RANGE_EN = 10'h1D5;
  localparam logic [MN*SN-1:0] VISIBLE  = 10'h37F;

  logic           clk = 1'b0;
  logic           rst;
  logic [0:0]     s_master_id;
  logic           s_psel, s_penable, s_pwrite;
  logic [AW-1:0]  s_paddr;
  logic [DW-1:0]  s_pwdata, s_prdata;
  logic           s_pready, s_pslverr;
  logic [SN-1:0]  m_psel;
  logic           m_penable, m_pwrite;
  logic [AW-1:0]  m_paddr;
  logic [DW-1:0]  m_pwdata;
  logic [SN*DW-1:0] m_prdata;
  logic [SN-1:0]  m_pready, m_pslverr;

  int n_assert = 0;
  int n_fail   = 0;

  apb_dec_split #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MASTER_NUM (MN), .SLAVE_NUM (SN), .RANGE_NUM (RN),
    .SLAVE_START_ADDRS (STARTS), .SLAVE_END_ADDRS (ENDS),
    .SLAVE_RANGE_EN (RANGE_EN), .SLAVE_VISIBLE (VISIBLE), .TIMEOUT_CYC (8)
  ) dut (
    .clk (clk), .rst (rst), .s_master_id (s_master_id),
    .s_psel (s_psel), .s_penable (s_penable), .s_pwrite (s_pwrite),
    .s_paddr (s_paddr), .s_pwdata (s_pwdata), .s_prdata (s_prdata),
    .s_pready (s_pready), .s_pslverr (s_pslverr),
    .m_psel (m_psel), .m_penable (m_penable), .m_pwrite (m_pwrite),
    .m_paddr (m_paddr), .m_pwdata (m_pwdata), .m_prdata (m_prdata),
    .m_pready (m_pready), .m_pslverr (m_pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an upstream setup phase; returns one edge later with PENABLE raised.
  task automatic start(input logic [0:0] id, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    s_master_id = id;
    s_psel      = 1'b1;
    s_penable   = 1'b0;
    s_pwrite    = wr;
    s_paddr     = addr;
    s_pwdata    = wdata;
    #1;
    chk("setup_cycle_no_ready", s_pready, 0);
    tick();
    s_penable = 1'b1;
  endtask

  task automatic release_up();
    s_psel    = 1'b0;
    s_penable = 1'b0;
  endtask

  task automatic hit_xfer(input string tag, input logic [0:0] id, input logic wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SN-1:0] exp_sel, input logic [DW-1:0] exp_rdata);
    start(id, wr, addr, wdata);
    chk({tag, "_setup_psel"}, m_psel, exp_sel);
    chk({tag, "_setup_pen"}, m_penable, 0);
    chk({tag, "_setup_pready"}, s_pready, 0);
    chk({tag, "_paddr"}, m_paddr, addr);
    chk({tag, "_pwrite"}, m_pwrite, wr);
    chk({tag, "_pwdata"}, m_pwdata, wdata);
    tick();
    chk({tag, "_acc_psel"}, m_psel, exp_sel);
    chk({tag, "_acc_pen"}, m_penable, 1);
    chk({tag, "_pready"}, s_pready, 1);
    chk({tag, "_prdata"}, s_prdata, exp_rdata);
    chk({tag, "_pslverr"}, s_pslverr, 0);
    release_up();
    tick();
    chk({tag, "_done_psel"}, m_psel, 0);
    chk({tag, "_done_pen"}, m_penable, 0);
    chk({tag, "_done_pready"}, s_pready, 0);
  endtask

  task automatic miss_xfer(input string tag, input logic [0:0] id, input logic wr,
                           input logic [AW-1:0] addr);
    start(id, wr, addr, 32'h1234_5678);
    chk({tag, "_psel"}, m_psel, 0);
    chk({tag, "_pready"}, s_pready, 1);
    chk({tag, "_pslverr"}, s_pslverr, 1);
    chk({tag, "_prdata"}, s_prdata, 0);
    release_up();
    tick();
    chk({tag, "_after_pready"}, s_pready, 0);
    chk({tag, "_after_psel"}, m_psel, 0);
  endtask

  initial begin
    rst         = 1'b1;
    s_master_id = 1'b0;
    s_psel      = 1'b0;
    s_penable   = 1'b0;
    s_pwrite    = 1'b0;
    s_paddr     = '0;
    s_pwdata    = '0;
    m_prdata    = {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    m_pready    = 5'b11111;
    m_pslverr   = 5'b00000;
    tick();
    tick();
    chk("rst_m_psel", m_psel, 0);
    chk("rst_m_penable", m_penable, 0);
    chk("rst_m_pwrite", m_pwrite, 0);
    chk("rst_m_paddr", m_paddr, 0);
    chk("rst_m_pwdata", m_pwdata, 0);
    chk("rst_s_pready", s_pready, 0);
    chk("rst_s_pslverr", s_pslverr, 0);
    chk("rst_s_prdata", s_prdata, 0);
    rst = 1'b0;
    tick();

    hit_xfer("rd_s1", 1'b0, 1'b0, 32'h0005_0010, 32'h0, 5'b00010, 32'hA5A5_0001);
    miss_xfer("wr_unmapped", 1'b0, 1'b1, 32'h0009_0000);
    miss_xfer("m1_invisible", 1'b1, 1'b0, 32'h0006_0000);
    hit_xfer("m0_visible", 1'b0, 1'b0, 32'h0006_0000, 32'h0, 5'b00100, 32'hA5A5_0002);
    hit_xfer("s3_range1_end", 1'b0, 1'b0, 32'h0010_0FFF, 32'h0, 5'b01000, 32'hA5A5_0003);
    miss_xfer("s3_range1_past", 1'b0, 1'b0, 32'h0010_1000);
    hit_xfer("s0_low_edge", 1'b0, 1'b1, 32'h0004_0000, 32'hCAFE_0001, 5'b00001, 32'hA5A5_0000);
    miss_xfer("below_s0", 1'b0, 1'b0, 32'h0003_FFFF);
    hit_xfer("s4_high_edge_m1", 1'b1, 1'b0, 32'h0008_FFFF, 32'h0, 5'b10000, 32'hA5A5_0004);

    // Slave 4 stalls five access cycles, then completes with an error.
    m_pready  = 5'b01111;
    m_pslverr = 5'b10000;
    start(1'b0, 1'b1, 32'h0008_0004, 32'hBEEF_0004);
    chk("wait_setup_psel", m_psel, 5'b10000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait_no_pready", s_pready, 0);
      chk("wait_pen", m_penable, 1);
      chk("wait_paddr_stable", m_paddr, 32'h0008_0004);
    end
    m_pready = 5'b11111;
    #1;
    chk("wait_done_pready", s_pready, 1);
    chk("wait_done_pslverr", s_pslverr, 1);
    release_up();
    tick();
    chk("wait_after_pready", s_pready, 0);
    chk("wait_after_psel", m_psel, 0);
    chk("wait_after_pen", m_penable, 0);

    // Reset during the third wait cycle aborts the transfer.
    m_pready  = 5'b01111;
    m_pslverr = 5'b00000;
    start(1'b0, 1'b0, 32'h0008_0000, 32'h0);
    tick();
    tick();
    tick();
    chk("abort_pre_pen", m_penable, 1);
    rst = 1'b1;
    #1;
    chk("abort_psel", m_psel, 0);
    chk("abort_pen", m_penable, 0);
    chk("abort_paddr", m_paddr, 0);
    chk("abort_pready", s_pready, 0);
    tick();
    chk("abort_edge_pready", s_pready, 0);
    chk("abort_edge_pslverr", s_pslverr, 0);
    release_up();
    rst      = 1'b0;
    m_pready = 5'b11111;
    tick();
    hit_xfer("post_abort", 1'b0, 1'b0, 32'h0005_0010, 32'h0, 5'b00010, 32'hA5A5_0001);

`ifdef APB_DEC_SPLIT_TIMEOUT_EN
    m_pready = 5'b00000;
    start(1'b0, 1'b0, 32'h0004_0000, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("to_wait_pready", s_pready, 0);
    end
    tick();
    chk("to_pready", s_pready, 1);
    chk("to_pslverr", s_pslverr, 1);
    chk("to_prdata", s_prdata, 0);
    chk("to_psel_held", m_psel, 5'b00001);
    release_up();
    tick();
    chk("to_after_psel", m_psel, 0);
    chk("to_after_pen", m_penable, 0);
    chk("to_after_pready", s_pready, 0);
    m_pready = 5'b11111;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_dec_split.md
Name: apb_dec_split

Overview:
- Registered APB 1-to-N splitter with integrated multi-range address decoder and per-master visibility filtering.
- Sits between the AXI-to-APB bridge and the APB peripheral slaves.
- Generalises the combinational decoder: multiple address ranges per slave, runtime master visibility, internal error slave, and downstream APB phase sequencing.
- Unmapped or invisible addresses complete upstream with PSLVERR instead of hanging.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- MASTER_NUM, 2, number of upstream master IDs.
- SLAVE_NUM, 5, number of downstream APB slaves.
- RANGE_NUM, 2, maximum address ranges per slave.
- SLAVE_START_ADDRS, slave k range 0 = 0x0004_0000 + k*0x1_0000, flattened [SLAVE_NUM*RANGE_NUM*ADDR_WIDTH] start addresses. Index = slave*RANGE_NUM + range.
- SLAVE_END_ADDRS, slave k range 0 = 0x0004_FFFF + k*0x1_0000, flattened inclusive end addresses.
- SLAVE_RANGE_EN, range 0 only, [SLAVE_NUM*RANGE_NUM] valid mask per range.
- SLAVE_VISIBLE, all ones, [MASTER_NUM*SLAVE_NUM]. Bit m*SLAVE_NUM+s set means slave s is visible to master m.
- TIMEOUT_CYC, 256, downstream access-phase cycle limit (only used when the timeout feature is compiled in).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_master_id  in  clog2(MASTER_NUM)  master ID of the upstream transfer.
- s_psel  in  1  upstream PSEL.
- s_penable  in  1  upstream PENABLE.
- s_pwrite  in  1  upstream PWRITE.
- s_paddr  in  ADDR_WIDTH  upstream PADDR.
- s_pwdata  in  DATA_WIDTH  upstream PWDATA.
- s_prdata  out  DATA_WIDTH  upstream PRDATA.
- s_pready  out  1  upstream PREADY.
- s_pslverr  out  1  upstream PSLVERR.
- m_psel  out  SLAVE_NUM  one-hot downstream PSEL.
- m_penable  out  1  downstream PENABLE.
- m_pwrite  out  1  registered PWRITE.
- m_paddr  out  ADDR_WIDTH  registered PADDR.
- m_pwdata  out  DATA_WIDTH  registered PWDATA.
- m_prdata  in  SLAVE_NUM*DATA_WIDTH  downstream PRDATA, packed, slave 0 in the LSBs.
- m_pready  in  SLAVE_NUM  downstream PREADY per slave.
- m_pslverr  in  SLAVE_NUM  downstream PSLVERR per slave.

Behaviour:
- Reset: state IDLE; m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, s_pready=0, s_pslverr=0, s_prdata=0.
- Reset asserted mid-transfer aborts it: no upstream completion is produced.
- Decode:
  - Hit on slave s when addr is within [start,end] of any enabled range of s AND SLAVE_VISIBLE[id*SLAVE_NUM+s]=1.
  - Lowest slave index wins on overlap.
  - Out-of-range s_master_id (>= MASTER_NUM) is always a miss.
  - Comparisons are unsigned and inclusive at both ends.
- FSM states and transitions:
  - IDLE: when s_psel=1 and s_penable=0, register paddr/pwdata/pwrite, the one-hot hit vector and hit/miss. Go to SETUP on hit, ERR on miss.
  - SETUP (1 cycle): m_psel=hit vector, m_penable=0. Go to ACCESS.
  - ACCESS: m_psel held, m_penable=1. When m_pready[sel]=1:
    - same cycle, combinationally: s_pready=1, s_prdata=m_prdata[sel], s_pslverr=m_pslverr[sel];
    - next cycle: m_psel=0, m_penable=0, state IDLE.
  - ERR (1 cycle): s_pready=1, s_pslverr=1, s_prdata=0. Next state IDLE.
- Upstream outside completion cycles: s_pready=0, s_pslverr=0, s_prdata=0.
- Latency: minimum 2 cycles from the upstream setup cycle to upstream PREADY on a hit, 1 cycle on a miss.
- Back-to-back: a new upstream setup is accepted in the IDLE cycle immediately after a completion.
- If s_psel drops mid-transfer (protocol violation), the downstream transfer still completes and the upstream response is driven and ignored.
- Downstream address, data and write signals stay stable from SETUP through the last ACCESS cycle.

Optional Feature:
- Macro: APB_DEC_SPLIT_TIMEOUT_EN.
- Defined:
  - A clog2(TIMEOUT_CYC)-bit counter clears on entry to ACCESS and increments each ACCESS cycle with m_pready[sel]=0.
  - At count TIMEOUT_CYC-1 without ready: s_pready=1, s_pslverr=1, s_prdata=0. Next cycle: m_psel and m_penable deasserted, state IDLE.
  - If ready and timeout coincide, ready wins.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_dec_split_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, ERR);
  - a clog2-style width helper function;
  - a reset-value constant for the data bus.
- Sub-module apb_range_dec: combinational multi-range, visibility-filtered, priority decoder. Outputs a one-hot hit vector and a hit flag.

Test Plan:
- Read from master 0 at 0x0005_0010, slave 1 ready immediately with prdata 0xA5A5_0001 -> m_psel=5'b00010 for 2 cycles; s_pready on upstream cycle +2 with s_prdata=0xA5A5_0001 and s_pslverr=0.
- Write to 0x0009_0000 (unmapped) -> no m_psel; s_pready=1 and s_pslverr=1 one cycle after setup.
- SLAVE_VISIBLE bit for master 1, slave 2 cleared; master 1 accesses 0x0006_0000 -> error response with no downstream select. The same access from master 0 succeeds.
- Second range 0x0010_0000..0x0010_0FFF enabled for slave 3, access 0x0010_0FFF -> m_psel=5'b01000. Access 0x0010_1000 -> error response.
- Slave 4 holds pready low for 5 cycles and returns pslverr=1 -> s_pready asserts exactly once with s_pslverr=1. Reset asserted on wait cycle 3 -> all outputs 0 next edge, state IDLE.
- With the timeout macro defined and TIMEOUT_CYC=8, slave never ready -> s_pslverr=1 on ACCESS cycle 8, m_psel cleared the following cycle.
